// File: rtl/bp_cce_lce_cmd_arbiter_if.sv
// bp_cce_lce_cmd_arbiter_if: requester and LCE command port handshake bundle for the arbiter
interface bp_cce_lce_cmd_arbiter_if #(
    parameter int header_width_p = 128,
    parameter int data_width_p = 64
);
    logic ucode_v_i;
    logic [header_width_p-1:0] ucode_header_i;
    logic [data_width_p-1:0] ucode_data_i;
    logic ucode_last_i;
    logic ucode_ready_o;
    logic msg_v_i;
    logic [header_width_p-1:0] msg_header_i;
    logic [data_width_p-1:0] msg_data_i;
    logic msg_last_i;
    logic msg_ready_o;
    logic [header_width_p-1:0] lce_cmd_header_o;
    logic [data_width_p-1:0] lce_cmd_data_o;
    logic lce_cmd_v_o;
    logic lce_cmd_ready_i;
    logic lce_cmd_busy_o;
    logic owner_o;

    modport slave (
        input ucode_v_i, ucode_header_i, ucode_data_i, ucode_last_i,
        input msg_v_i, msg_header_i, msg_data_i, msg_last_i, lce_cmd_ready_i,
        output ucode_ready_o, msg_ready_o, lce_cmd_header_o, lce_cmd_data_o,
        output lce_cmd_v_o, lce_cmd_busy_o, owner_o
    );

    modport master (
        output ucode_v_i, ucode_header_i, ucode_data_i, ucode_last_i,
        output msg_v_i, msg_header_i, msg_data_i, msg_last_i, lce_cmd_ready_i,
        input ucode_ready_o, msg_ready_o, lce_cmd_header_o, lce_cmd_data_o,
        input lce_cmd_v_o, lce_cmd_busy_o, owner_o
    );
endinterface

// File: rtl/bp_cce_lce_cmd_arbiter.sv
// bp_cce_lce_cmd_arbiter: shares the CCE LCE command port between ucode and msg with
// multi-beat locking and a starvation bound on msg priority
module bp_cce_lce_cmd_arbiter #(
    parameter int header_width_p = 128,
    parameter int data_width_p = 64,
    parameter int max_starve_p = 4
) (
    input logic clk_i,
    input logic reset_i,
    bp_cce_lce_cmd_arbiter_if.slave bus
);
    localparam int cnt_w = $clog2(max_starve_p + 1);
    localparam logic [cnt_w-1:0] max_c = cnt_w'(max_starve_p);

    typedef enum logic [1:0] {IDLE = 2'd0, LOCK_UCODE = 2'd1, LOCK_MSG = 2'd2} state_t;

    state_t state, state_n;
    logic [cnt_w-1:0] starve_cnt;
    logic grant_msg, last, xfer;
    logic [header_width_p-1:0] header;
    logic [data_width_p-1:0] data;

    // msg keeps priority in IDLE until ucode has watched max_starve_p msg messages go by
    assign grant_msg = (state == LOCK_MSG) |
                       ((state == IDLE) & bus.msg_v_i & (~bus.ucode_v_i | (starve_cnt != max_c)));
    assign last = grant_msg ? bus.msg_last_i : bus.ucode_last_i;
    assign xfer = bus.lce_cmd_v_o & bus.lce_cmd_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (xfer)
            state_n = last ? IDLE : (state != IDLE) ? state : grant_msg ? LOCK_MSG : LOCK_UCODE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) starve_cnt <= '0;
        else if (xfer & last & ~grant_msg) starve_cnt <= '0;
        else if (xfer & last & grant_msg & bus.ucode_v_i & (starve_cnt != max_c))
            starve_cnt <= starve_cnt + 1'b1;
    end

    always_comb begin
        header = grant_msg ? bus.msg_header_i : bus.ucode_header_i;
        data = grant_msg ? bus.msg_data_i : bus.ucode_data_i;
        bus.lce_cmd_header_o = header;
        bus.lce_cmd_data_o = data;
        bus.owner_o = ~reset_i & grant_msg;
        bus.lce_cmd_v_o = ~reset_i & (grant_msg ? bus.msg_v_i : bus.ucode_v_i);
        bus.ucode_ready_o = ~reset_i & ~grant_msg & bus.lce_cmd_ready_i;
        bus.msg_ready_o = ~reset_i & grant_msg & bus.lce_cmd_ready_i;
        bus.lce_cmd_busy_o = ~reset_i & ((state == LOCK_MSG) | ((state == IDLE) & bus.msg_v_i & grant_msg));
    end

    // a waiting requester must hold its beat steady until it is accepted
    a_ucode_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.ucode_v_i & ~bus.ucode_ready_o |=>
        ~bus.ucode_v_i | ($stable(bus.ucode_header_i) & $stable(bus.ucode_data_i)));
    a_msg_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.msg_v_i & ~bus.msg_ready_o |=>
        ~bus.msg_v_i | ($stable(bus.msg_header_i) & $stable(bus.msg_data_i)));
endmodule

// File: tb/tb_bp_cce_lce_cmd_arbiter.sv
// tb_bp_cce_lce_cmd_arbiter: table-driven and directed checks of the LCE command arbiter
module tb_bp_cce_lce_cmd_arbiter;
    localparam int hw = 128;
    localparam int dw = 64;
    localparam logic [hw-1:0] uh = {32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
    localparam logic [hw-1:0] mh = {32'h2222_0001, 32'h2222_0002, 32'h2222_0003, 32'h2222_0004};
    localparam logic [dw-1:0] ud = 64'hAAAA_0000_0000_0011;
    localparam logic [dw-1:0] md = 64'hBBBB_0000_0000_0022;

    typedef struct {
        bit uv, ul, mv, ml, rdy;
        bit e_own, e_v, e_ur, e_mr, e_busy;
    } vec_t;

    logic clk_i = 0;
    logic reset_i;
    int total = 0;
    int bad = 0;
    vec_t vec[17];

    bp_cce_lce_cmd_arbiter_if #(.header_width_p(hw), .data_width_p(dw)) bus ();

    bp_cce_lce_cmd_arbiter #(.header_width_p(hw), .data_width_p(dw), .max_starve_p(4)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .bus(bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [hw-1:0] act, input logic [hw-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit uv, input bit ul, input bit mv, input bit ml, input bit rdy);
        bus.ucode_v_i = uv;
        bus.ucode_last_i = ul;
        bus.msg_v_i = mv;
        bus.msg_last_i = ml;
        bus.lce_cmd_ready_i = rdy;
        #1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string n, input bit own, input bit v, input bit ur, input bit mr, input bit busy);
        chk({n, " owner"}, hw'(bus.owner_o), hw'(own));
        chk({n, " v"}, hw'(bus.lce_cmd_v_o), hw'(v));
        chk({n, " ucode_ready"}, hw'(bus.ucode_ready_o), hw'(ur));
        chk({n, " msg_ready"}, hw'(bus.msg_ready_o), hw'(mr));
        chk({n, " busy"}, hw'(bus.lce_cmd_busy_o), hw'(busy));
        if (v) begin
            chk({n, " header"}, bus.lce_cmd_header_o, own ? mh : uh);
            chk({n, " data"}, hw'(bus.lce_cmd_data_o), hw'(own ? md : ud));
        end
    endtask

    task automatic do_reset();
        reset_i = 1;
        step();
        reset_i = 0;
    endtask

    initial begin
        // uv ul mv ml rdy | owner v ur mr busy ; starts in IDLE with starve_cnt=0
        vec[0]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        vec[1]  = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0};
        vec[2]  = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[3]  = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 1};
        vec[4]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[5]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[6]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[7]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[8]  = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        vec[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[10] = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 1};
        vec[11] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        vec[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        vec[13] = '{1, 0, 0, 0, 1, 0, 1, 1, 0, 0};
        vec[14] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
        vec[15] = '{1, 1, 1, 0, 1, 0, 1, 1, 0, 0};
        vec[16] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};

        bus.ucode_header_i = uh;
        bus.ucode_data_i = ud;
        bus.msg_header_i = mh;
        bus.msg_data_i = md;
        reset_i = 1;
        drive(1, 1, 1, 1, 1);
        step();
        chk_out("reset", 0, 0, 0, 0, 0);
        reset_i = 0;

        for (int i = 0; i < 17; i++) begin
            drive(vec[i].uv, vec[i].ul, vec[i].mv, vec[i].ml, vec[i].rdy);
            chk_out($sformatf("vec%0d", i), vec[i].e_own, vec[i].e_v, vec[i].e_ur, vec[i].e_mr, vec[i].e_busy);
            step();
        end

        // ucode 3-beat message locks out msg until the cycle after its last beat
        drive(0, 0, 0, 0, 1);
        do_reset();
        drive(1, 0, 0, 0, 1);
        chk_out("u3 beat1", 0, 1, 1, 0, 0);
        step();
        drive(1, 0, 1, 1, 1);
        chk_out("u3 beat2", 0, 1, 1, 0, 0);
        step();
        drive(1, 1, 1, 1, 1);
        chk_out("u3 beat3", 0, 1, 1, 0, 0);
        step();
        drive(0, 0, 1, 1, 1);
        chk_out("u3 after", 1, 1, 0, 1, 1);
        step();

        // msg 2-beat message stalled downstream stays locked
        drive(0, 0, 1, 0, 1);
        chk_out("mstall beat1", 1, 1, 0, 1, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 0);
            chk_out($sformatf("mstall wait%0d", i), 1, 1, 0, 0, 1);
            step();
        end
        drive(1, 1, 1, 1, 1);
        chk_out("mstall beat2", 1, 1, 0, 1, 1);
        step();
        drive(1, 1, 0, 0, 1);
        chk_out("mstall ucode", 0, 1, 1, 0, 0);
        step();

        // saturate starve_cnt so that reset clearing it becomes observable
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 1, 1);
            chk_out($sformatf("pump%0d", i), 1, 1, 0, 1, 1);
            step();
        end
        drive(0, 0, 1, 0, 1);
        chk_out("rst lock", 1, 1, 0, 1, 1);
        step();
        drive(0, 0, 1, 0, 1);
        chk_out("rst locked", 1, 1, 0, 1, 1);
        reset_i = 1;
        #1;
        chk_out("rst async", 0, 0, 0, 0, 0);
        step();
        reset_i = 0;
        drive(1, 1, 0, 0, 1);
        chk_out("rst ucode", 0, 1, 1, 0, 0);
        step();
        drive(1, 1, 1, 1, 1);
        chk_out("rst starve0", 1, 1, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_cce_lce_cmd_arbiter.md
Name: bp_cce_lce_cmd_arbiter

Overview:
- Shares the single CCE LCE command output port between two requesters: the microcode datapath (ucode) and the message unit's auto-forward/invalidation engine (msg).
- Multi-beat messages are locked to one owner until their last beat.
- A starvation counter bounds how long msg priority can block ucode.
- Produces lce_cmd_busy_o, which feeds the instruction stall unit's msg_lce_cmd_busy input.

Parameters:
- header_width_p, 128, LCE command header width in bits.
- data_width_p, 64, LCE command data beat width in bits.
- max_starve_p, 4, consecutive msg message grants allowed while ucode waits; must be ≥1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- ucode_v_i  in  1  ucode beat valid
- ucode_header_i  in  header_width_p  ucode header; held stable across beats
- ucode_data_i  in  data_width_p  ucode data beat
- ucode_last_i  in  1  final beat of the ucode message
- ucode_ready_o  out  1  ucode beat accepted this cycle (ready-valid)
- msg_v_i  in  1  msg beat valid
- msg_header_i  in  header_width_p  msg header
- msg_data_i  in  data_width_p  msg data beat
- msg_last_i  in  1  final beat of the msg message
- msg_ready_o  out  1  msg beat accepted this cycle
- lce_cmd_header_o  out  header_width_p  muxed header
- lce_cmd_data_o  out  data_width_p  muxed data
- lce_cmd_v_o  out  1  output beat valid
- lce_cmd_ready_i  in  1  downstream ready (ready-valid)
- lce_cmd_busy_o  out  1  port owned or claimed by msg this cycle
- owner_o  out  1  current grant: 0 = ucode, 1 = msg

Behaviour:
- States: IDLE, LOCK_UCODE, LOCK_MSG, encoded in two flops. The starvation counter starve_cnt is $clog2(max_starve_p+1) bits wide.
- Reset is asynchronous. It forces IDLE and starve_cnt=0. While reset_i=1: lce_cmd_v_o=0, ucode_ready_o=0, msg_ready_o=0, lce_cmd_busy_o=0, owner_o=0. Header/data outputs are don't-care.
- Grant in IDLE is combinational, with zero-cycle latency:
  - Only one requester valid: it wins.
  - Both valid: msg wins unless starve_cnt==max_starve_p, in which case ucode wins.
  - Neither valid: owner_o=0 and lce_cmd_v_o=0.
- Grant in LOCK_UCODE / LOCK_MSG: only the locked owner may drive. The other requester gets ready=0 regardless of its valid.
- Datapath:
  - lce_cmd_v_o = granted requester's valid.
  - Header and data are muxed from the granted requester.
  - Granted requester's ready = lce_cmd_ready_i. Non-granted ready = 0.
  - A beat transfers when lce_cmd_v_o & lce_cmd_ready_i.
- Transitions:
  - IDLE: on transfer with last=0, go to LOCK_<owner>. On transfer with last=1 (single-beat message), stay in IDLE.
  - LOCK_x: on transfer with last=1, go to IDLE. Otherwise hold.
  - Holding valid without ready never changes state.
- Starvation counter:
  - Increments, saturating at max_starve_p, on a msg last-beat transfer while ucode_v_i=1.
  - Clears to 0 on a ucode last-beat transfer.
  - Holds otherwise, including when ucode_v_i drops.
- lce_cmd_busy_o = (state==LOCK_MSG) | (state==IDLE & msg_v_i & owner_o==1). It is asserted in the same cycle msg claims the port, so the stall unit blocks any ucode instruction that sends an LCE command.
- Simultaneous last-beat transfer and new requests: the return to IDLE takes effect next cycle, and the new arbitration happens there. There is no back-to-back grant inside a lock state.
- Reset mid-message: the lock is dropped immediately. Requesters must restart their messages after reset deasserts.
- Requester protocol: valid must not depend on ready, and header/data must be stable while valid=1 and ready=0. Violations are assertion errors in simulation.

Test Plan:
- Single-beat requests from both sides in the same cycle, ready=1, max_starve_p=4, starve_cnt=0 -> msg granted (owner_o=1, msg_ready_o=1, ucode_ready_o=0, lce_cmd_busy_o=1); starve_cnt=1 next cycle.
- ucode 3-beat message (last on beat 3) started in IDLE; msg_v_i=1 from beat 2 -> state LOCK_UCODE after beat 1; msg_ready_o=0 through beat 3; msg granted only in the cycle after beat 3.
- ucode_v_i and msg_v_i held high with continuous single-beat msg messages, max_starve_p=4 -> exactly 4 msg grants, then ucode granted on the 5th transfer; starve_cnt returns to 0.
- msg 2-beat message with lce_cmd_ready_i=0 for 3 cycles after beat 1 -> state stays LOCK_MSG; lce_cmd_v_o=1 and lce_cmd_busy_o=1 throughout the stall; no ucode grant.
- reset_i asserted mid-way through a LOCK_MSG message -> outputs go to 0 in the same cycle without a clock edge; after reset deasserts, ucode alone valid is granted immediately and starve_cnt=0.
